// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// matrix_pkg : opcodes, register map and types shared by the matrix ALU
// Rev 1.0
// ============================================================================
package matrix_pkg;

  localparam int ELEM_W = 16;
  localparam int N_ELEM = 16;
  localparam logic [15:0] BASE_ADDR_DEFAULT = 16'h3000;

  typedef logic [ELEM_W-1:0]        elem_t;
  typedef logic [N_ELEM*ELEM_W-1:0] matrix_t;
  typedef logic [7:0]               opcode_t;

  localparam opcode_t OP_STOP      = 8'hFF;
  localparam opcode_t OP_ADD       = 8'h01;
  localparam opcode_t OP_SUB       = 8'h02;
  localparam opcode_t OP_TRANSPOSE = 8'h03;
  localparam opcode_t OP_SCALE     = 8'h04;
  localparam opcode_t OP_SCALE_IMM = 8'h05;
  // Engine-side opcodes that share the encoding space but never reach this unit
  localparam opcode_t OP_ENG_10    = 8'h10;
  localparam opcode_t OP_ENG_11    = 8'h11;
  localparam opcode_t OP_ENG_12    = 8'h12;
  localparam opcode_t OP_ENG_13    = 8'h13;

  localparam logic [3:0] REG_SRC1   = 4'h0;
  localparam logic [3:0] REG_SRC2   = 4'h1;
  localparam logic [3:0] REG_CMD    = 4'h2;
  localparam logic [3:0] REG_RESULT = 4'h3;
  localparam logic [3:0] REG_STATUS = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  function automatic logic is_alu_op(input opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_TRANSPOSE, OP_SCALE, OP_SCALE_IMM: return 1'b1;
      OP_STOP, OP_ENG_10, OP_ENG_11, OP_ENG_12, OP_ENG_13:  return 1'b0;
      default:                                              return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_elem_op.sv
`default_nettype none
// ============================================================================
// matrix_elem_op : combinational single-element operator (MATRIX_ALU_SATURATE_EN)
// Rev 1.0
// ============================================================================
module matrix_elem_op
  import matrix_pkg::*;
(
  input  opcode_t op_i,
  input  elem_t   a_i,
  input  elem_t   b_i,
  input  elem_t   scalar_i,
  output elem_t   y_o
);

`ifdef MATRIX_ALU_SATURATE_EN
  function automatic elem_t sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)  return 16'h7FFF;
    if (v < -32'sd32768) return 16'h8000;
    return v[15:0];
  endfunction

  logic signed [31:0] a_s, b_s, k_s;
  assign a_s = {{16{a_i[15]}}, a_i};
  assign b_s = {{16{b_i[15]}}, b_i};
  assign k_s = {{16{scalar_i[15]}}, scalar_i};

  always_comb begin
    y_o = a_i;
    case (op_i)
      OP_ADD:                 y_o = sat16(a_s + b_s);
      OP_SUB:                 y_o = sat16(a_s - b_s);
      OP_SCALE, OP_SCALE_IMM: y_o = sat16(a_s * k_s);
      default:                ;
    endcase
  end
`else
  always_comb begin
    y_o = a_i;
    case (op_i)
      OP_ADD:                 y_o = a_i + b_i;
      OP_SUB:                 y_o = a_i - b_i;
      OP_SCALE, OP_SCALE_IMM: y_o = a_i * scalar_i;
      default:                ;
    endcase
  end
`endif

endmodule
`default_nettype wire

// File: rtl/matrix_alu_responder.sv
`default_nettype none
// ============================================================================
// matrix_alu_responder : memory-mapped 4x4 matrix ALU on the engine bus
// Optional saturation via MATRIX_ALU_SATURATE_EN.  Rev 1.0
// ============================================================================
module matrix_alu_responder
  import matrix_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        nRead,
  input  logic        nWrite,
  input  logic [15:0] address,
  input  matrix_t     ExeDataOut,
  output matrix_t     AluDataOut
);

  state_e     state_q, state_d;
  matrix_t    src1_q, src1_d, src2_q, src2_d;
  matrix_t    result_q, result_d, shadow_q, shadow_d;
  matrix_t    rdata_q, rdata_d, dout_q;
  opcode_t    op_q, op_d;
  elem_t      imm_q, imm_d;
  logic [4:0] idx_q, idx_d;
  logic       done_q, done_d, err_q, err_d;
  logic       nwrite_prev_q;

  logic       hit, wr_stb, rd_stb, busy;
  logic [3:0] offset, el_idx;
  logic [7:0] a_base, b_base;
  elem_t      a_el, b_el, k_el, y_el;
  opcode_t    cmd_op;

  assign hit    = (address[15:4] == BASE_ADDR[15:4]);
  assign offset = address[3:0];
  assign wr_stb = hit && !nWrite && nwrite_prev_q;
  assign rd_stb = hit && !nRead && nWrite;
  assign busy   = (state_q == ST_COMPUTE);
  assign cmd_op = ExeDataOut[31:24];

  // Transpose fetches src1 at the mirrored (col,row) position
  assign el_idx = (op_q == OP_TRANSPOSE) ? {idx_q[1:0], idx_q[3:2]} : idx_q[3:0];
  assign a_base = {el_idx, 4'h0};
  assign b_base = {idx_q[3:0], 4'h0};
  assign a_el   = src1_q[a_base +: ELEM_W];
  assign b_el   = src2_q[b_base +: ELEM_W];
  assign k_el   = (op_q == OP_SCALE) ? src2_q[ELEM_W-1:0] : imm_q;

  matrix_elem_op u_elem_op (
    .op_i     (op_q),
    .a_i      (a_el),
    .b_i      (b_el),
    .scalar_i (k_el),
    .y_o      (y_el)
  );

  always_comb begin
    state_d  = state_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    result_d = result_q;
    shadow_d = shadow_q;
    op_d     = op_q;
    imm_d    = imm_q;
    idx_d    = idx_q;
    done_d   = done_q;
    err_d    = err_q;

    case (state_q)
      ST_COMPUTE: begin
        // One extra cycle after element 15 commits the shadow buffer
        if (idx_q == 5'd16) begin
          result_d = shadow_q;
          done_d   = 1'b1;
          idx_d    = '0;
          state_d  = ST_DONE;
        end else begin
          shadow_d[b_base +: ELEM_W] = y_el;
          idx_d = idx_q + 5'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: ;
    endcase

    if (wr_stb) begin
      case (offset)
        REG_SRC1: if (busy) err_d = 1'b1; else src1_d = ExeDataOut;
        REG_SRC2: if (busy) err_d = 1'b1; else src2_d = ExeDataOut;
        REG_CMD: begin
          if (busy || !is_alu_op(cmd_op)) begin
            err_d = 1'b1;
          end else begin
            op_d    = cmd_op;
            imm_d   = ExeDataOut[15:0];
            idx_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            state_d = ST_COMPUTE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_stb) begin
      case (offset)
        REG_SRC1:   rdata_d = src1_q;
        REG_SRC2:   rdata_d = src2_q;
        REG_RESULT: rdata_d = result_q;
        REG_STATUS: rdata_d[2:0] = {err_q, done_q, busy};
        default:    ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q       <= ST_IDLE;
      src1_q        <= '0;
      src2_q        <= '0;
      result_q      <= '0;
      shadow_q      <= '0;
      rdata_q       <= '0;
      dout_q        <= '0;
      op_q          <= '0;
      imm_q         <= '0;
      idx_q         <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      nwrite_prev_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      src1_q        <= src1_d;
      src2_q        <= src2_d;
      result_q      <= result_d;
      shadow_q      <= shadow_d;
      rdata_q       <= rdata_d;
      dout_q        <= rdata_q;
      op_q          <= op_d;
      imm_q         <= imm_d;
      idx_q         <= idx_d;
      done_q        <= done_d;
      err_q         <= err_d;
      nwrite_prev_q <= nWrite;
    end
  end

  assign AluDataOut = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_alu_responder.sv
`default_nettype none
// Bench for matrix_alu_responder: bus traffic checked by a scoreboard fed from
// a matrix-level reference model (result computed whole when a command is accepted).
module tb_matrix_alu_responder;

  localparam logic [15:0] BASE = 16'h3000;
  localparam int OFF_SRC1 = 0, OFF_SRC2 = 1, OFF_CMD = 2, OFF_RESULT = 3, OFF_STATUS = 4;
`ifdef MATRIX_ALU_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         Clk = 1'b0;
  logic         nReset = 1'b0;
  logic         nRead = 1'b1;
  logic         nWrite = 1'b1;
  logic [15:0]  address = '0;
  logic [255:0] ExeDataOut = '0;
  logic [255:0] AluDataOut;

  always #5 Clk = ~Clk;

  matrix_alu_responder #(.BASE_ADDR(BASE)) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .nRead      (nRead),
    .nWrite     (nWrite),
    .address    (address),
    .ExeDataOut (ExeDataOut),
    .AluDataOut (AluDataOut)
  );

  typedef struct {
    int           due;
    logic [255:0] exp;
    string        name;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int el(input logic [255:0] m, input int e);
    logic [255:0] t;
    t = m >> (16 * e);
    return int'({16'b0, t[15:0]});
  endfunction

  function automatic longint sx(input int x);
    if (SAT && x >= 32768) return longint'(x) - 65536;
    return longint'(x);
  endfunction

  function automatic logic [15:0] clamp(input longint v);
    if (SAT && v > 32767)  return 16'h7FFF;
    if (SAT && v < -32768) return 16'h8000;
    return 16'(v);
  endfunction

  function automatic logic [255:0] ref_op(input int op, input logic [255:0] s1,
                                          input logic [255:0] s2, input int imm);
    logic [255:0] r;
    longint a, b, k;
    logic [15:0] y;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        a = sx(el(s1, 4*row + col));
        b = sx(el(s2, 4*row + col));
        k = (op == 4) ? sx(el(s2, 0)) : sx(imm);
        case (op)
          1:       y = clamp(a + b);
          2:       y = clamp(a - b);
          3:       y = 16'(el(s1, 4*col + row));
          default: y = clamp(a * k);
        endcase
        r = r | ({240'b0, y} << (16 * (4*row + col)));
      end
    end
    return r;
  endfunction

  logic [255:0] m_src1, m_src2, m_result, m_pend, m_rd;
  logic         m_busy, m_done, m_err, m_prev_nwr, m_hit, m_b0;
  logic [3:0]   m_off;
  int           m_commit_at;
  int           ecnt = 0;
  string        m_name;

  always @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      m_src1 = '0; m_src2 = '0; m_result = '0; m_pend = '0;
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_prev_nwr = 1'b1;
      m_commit_at = 0;
    end else begin
      ecnt++;
      m_hit = ((address >> 4) == (BASE >> 4));
      m_off = address[3:0];
      m_b0  = m_busy;
      if (!nRead) begin
        m_rd   = '0;
        m_name = !m_hit ? "rd_outside" : (!nWrite ? "rd_wr_clash" : "rd_reg");
        if (m_hit && nWrite) begin
          case (int'(m_off))
            OFF_SRC1:   begin m_rd = m_src1;   m_name = "rd_src1";   end
            OFF_SRC2:   begin m_rd = m_src2;   m_name = "rd_src2";   end
            OFF_RESULT: begin m_rd = m_result; m_name = "rd_result"; end
            OFF_STATUS: begin m_rd = {253'b0, m_err, m_done, m_busy}; m_name = "rd_status"; end
            default:    m_name = "rd_zero_reg";
          endcase
        end
        sb.push_back('{ecnt + 1, m_rd, m_name});
      end
      if (m_b0 && ecnt == m_commit_at) begin
        m_result = m_pend;
        m_done   = 1'b1;
        m_busy   = 1'b0;
      end
      if (!nWrite && m_prev_nwr && m_hit) begin
        case (int'(m_off))
          OFF_SRC1: if (m_b0) m_err = 1'b1; else m_src1 = ExeDataOut;
          OFF_SRC2: if (m_b0) m_err = 1'b1; else m_src2 = ExeDataOut;
          OFF_CMD: begin
            if (m_b0 || ExeDataOut[31:24] < 8'h01 || ExeDataOut[31:24] > 8'h05) begin
              m_err = 1'b1;
            end else begin
              m_pend = ref_op(int'(ExeDataOut[31:24]), m_src1, m_src2, int'(ExeDataOut[15:0]));
              m_busy = 1'b1;
              m_done = 1'b0;
              m_err  = 1'b0;
              m_commit_at = ecnt + 17;
            end
          end
          default: ;
        endcase
      end
      m_prev_nwr = nWrite;
    end
  end

  // ---------------- monitor ----------------
  exp_t mon_e;
  always @(negedge Clk) begin
    if (sb.size() > 0 && sb[0].due == ecnt) begin
      mon_e = sb.pop_front();
      chk(mon_e.name, AluDataOut, mon_e.exp);
    end else begin
      chk("idle_zero", AluDataOut, '0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic bus(input bit rd, input bit wr, input logic [15:0] addr,
                     input logic [255:0] data, input int n);
    nRead = !rd; nWrite = !wr; address = addr; ExeDataOut = data;
    repeat (n) @(negedge Clk);
    nRead = 1'b1; nWrite = 1'b1;
    @(negedge Clk);
  endtask

  task automatic wr(input int off, input logic [255:0] d);
    bus(1'b0, 1'b1, BASE + 16'(off), d, 1);
  endtask

  task automatic rd(input int off, input int n);
    bus(1'b1, 1'b0, BASE + 16'(off), '0, n);
  endtask

  function automatic logic [255:0] cmd(input logic [7:0] op, input logic [15:0] imm);
    return {224'b0, op, 8'b0, imm};
  endfunction

  function automatic logic [255:0] fill(input logic [15:0] v);
    return {16{v}};
  endfunction

  function automatic logic [255:0] rnd_m();
    logic [255:0] m;
    for (int i = 0; i < 8; i++) m[32*i +: 32] = $urandom();
    return m;
  endfunction

  task automatic run_op(input logic [255:0] s1, input logic [255:0] s2, input logic [255:0] c);
    wr(OFF_SRC1, s1);
    wr(OFF_SRC2, s2);
    wr(OFF_CMD, c);
    repeat (18) @(negedge Clk);
    rd(OFF_RESULT, 1);
    rd(OFF_STATUS, 1);
  endtask

  logic [255:0] tm, tm2;

  initial begin
    repeat (3) @(negedge Clk);
    nReset = 1'b1;
    @(negedge Clk);
    rd(OFF_STATUS, 1); rd(OFF_RESULT, 1); rd(OFF_SRC1, 1); rd(OFF_SRC2, 1);

    // add, with STATUS watched across the whole busy window
    wr(OFF_SRC1, fill(16'h0003));
    wr(OFF_SRC2, fill(16'h0004));
    wr(OFF_CMD, cmd(8'h01, 16'h0));
    rd(OFF_STATUS, 20);
    rd(OFF_RESULT, 1);

    // sub with wrap, and 0x8000 - 1
    tm = rnd_m();  tm[15:0] = 16'h0001;
    tm2 = rnd_m(); tm2[15:0] = 16'h0002;
    run_op(tm, tm2, cmd(8'h02, 16'h0));
    run_op(fill(16'h8000), fill(16'h0001), cmd(8'h02, 16'h0));

    // transpose of element-index matrix
    for (int e = 0; e < 16; e++) tm[16*e +: 16] = 16'(e);
    run_op(tm, rnd_m(), cmd(8'h03, 16'h0));

    // scale immediate overflow, scale by SRC2 element 0
    run_op(fill(16'h0100), rnd_m(), cmd(8'h05, 16'h0200));
    run_op(rnd_m(), rnd_m(), cmd(8'h04, 16'h0));

    // writes during busy are ignored but flag error
    wr(OFF_SRC1, rnd_m()); wr(OFF_SRC2, rnd_m()); wr(OFF_CMD, cmd(8'h01, 16'h0));
    repeat (4) @(negedge Clk);
    wr(OFF_CMD, cmd(8'h02, 16'h0));
    wr(OFF_SRC1, fill(16'h0009));
    repeat (14) @(negedge Clk);
    rd(OFF_STATUS, 1); rd(OFF_RESULT, 1); rd(OFF_SRC1, 1);

    // illegal opcode
    wr(OFF_CMD, cmd(8'h77, 16'h0));
    rd(OFF_STATUS, 3);

    // 3-cycle write strobe launches one operation
    bus(1'b0, 1'b1, BASE + 16'(OFF_CMD), cmd(8'h01, 16'h0), 3);
    rd(OFF_STATUS, 20);
    rd(OFF_RESULT, 1);

    // outside window, reserved offsets, simultaneous read/write
    bus(1'b1, 1'b0, 16'h4003, '0, 1);
    bus(1'b1, 1'b0, 16'h2FFF, '0, 1);
    rd(5, 1);
    wr(7, rnd_m());
    rd(7, 1);
    bus(1'b0, 1'b1, 16'h4001, fill(16'h1111), 1);
    rd(OFF_SRC2, 1);
    bus(1'b1, 1'b1, BASE + 16'(OFF_SRC2), fill(16'hABCD), 1);
    rd(OFF_SRC2, 1);

    // reset during compute
    wr(OFF_CMD, cmd(8'h01, 16'h0));
    repeat (6) @(negedge Clk);
    nReset = 1'b0;
    @(negedge Clk);
    nReset = 1'b1;
    @(negedge Clk);
    rd(OFF_STATUS, 1); rd(OFF_RESULT, 1); rd(OFF_SRC1, 1);
    run_op(fill(16'h0003), fill(16'h0004), cmd(8'h01, 16'h0));

    // random operations
    for (int i = 0; i < 8; i++)
      run_op(rnd_m(), rnd_m(), cmd(8'($urandom_range(1, 5)), 16'($urandom())));

    repeat (4) @(negedge Clk);
    chk("sb_drain", 256'(sb.size()), '0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t required t<200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
